uart_echo_fifo: RTL and testbench

Buffered, mode-selectable echo engine placed between the uart receive side (dout/ready/rxerr) and transmit side (din/send/txbusy). Received bytes go into a synchronous FIFO and drain to the transmitter via the send/txbusy handshake, so back-to-back RX no longer drops bytes while TX is busy. Optional transforms (uppercase, CR→CR LF) and saturating error/overflow counters are for bring-up on the 12 MHz boards.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_echo_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_echo_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART echo path: mode selects, ASCII constants and TX FSM states.
package uart_pkg;

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_CRLF  = 2'd2;
    localparam logic [1:0] MODE_SINK  = 2'd3;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StDone,
        StLf
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with AW+1-bit pointers; the extra MSB tells full from empty.
module sync_fifo #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          srst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is refused.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PtrOne;
        if (do_pop)  rptr_d = rptr_q + PtrOne;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered echo engine: edge-captures RX bytes into a FIFO and drains them to the UART
// transmitter with optional uppercase / CR->CRLF transforms and saturating status counters.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned AW      = 4,
    parameter int unsigned CW      = 8,
    parameter bit          DropErr = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  rx_data,
    input  logic          rx_ready,
    input  logic          rx_err,
    output logic [W-1:0]  tx_data,
    output logic          tx_send,
    input  logic          tx_busy,
    input  logic [1:0]    mode,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    output logic [CW-1:0] drop_count,
    output logic [CW-1:0] err_count
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);

    tx_state_e     state_q, state_d;
    logic [W-1:0]  tx_data_q, tx_data_d;
    logic          tx_send_q, tx_send_d;
    logic          cr_q, cr_d;
    logic          rx_ready_q, rx_err_q;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] err_q, err_d;

    logic          capture, err_drop, fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [W-1:0]  fifo_head, head_xf;

    assign capture   = rx_ready && !rx_ready_q;
    assign err_drop  = DropErr && rx_err;
    assign fifo_push = capture && !fifo_full && !err_drop;

    sync_fifo #(
        .W  (W),
        .AW (AW)
    ) u_fifo (
        .clk_i   (clk),
        .srst_ni (reset),
        .push_i  (fifo_push),
        .wdata_i (rx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        drop_d     = drop_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        if (capture && (fifo_full || err_drop)) begin
            if (drop_q != CntMax) drop_d = drop_q + CntOne;
            if (fifo_full) overflow_d = 1'b1;
        end
        if (rx_err && !rx_err_q && (err_q != CntMax)) err_d = err_q + CntOne;
    end

    // FIFO keeps raw bytes; the transform is applied only as the head is loaded for TX.
    always_comb begin
        head_xf = fifo_head;
        if ((mode == MODE_UPPER) && (fifo_head >= W'(8'h61)) && (fifo_head <= W'(8'h7A))) begin
            head_xf = fifo_head - W'(8'h20);
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_send_d = tx_send_q;
        cr_d      = cr_q;
        fifo_pop  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (mode == MODE_SINK) fifo_pop = 1'b1;
                    else if (!tx_busy)     state_d = StLoad;
                end
            end
            StLoad: begin
                tx_data_d = head_xf;
                tx_send_d = 1'b1;
                cr_d      = (fifo_head == W'(CR));
                fifo_pop  = 1'b1;
                state_d   = StSend;
            end
            StSend: begin
                if (tx_busy) begin
                    tx_send_d = 1'b0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (!tx_busy) state_d = ((mode == MODE_CRLF) && cr_q) ? StLf : StIdle;
            end
            StLf: begin
                if (!tx_busy) begin
                    tx_data_d = W'(LF);
                    tx_send_d = 1'b1;
                    cr_d      = 1'b0;
                    state_d   = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            cr_q       <= 1'b0;
            rx_ready_q <= 1'b0;
            rx_err_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            cr_q       <= cr_d;
            rx_ready_q <= rx_ready;
            rx_err_q   <= rx_err;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_send    = tx_send_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo with a simple UART TX model and an expected-byte scoreboard.
module tb_uart_echo_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  rx_data = '0;
    logic          rx_ready = 1'b0;
    logic          rx_err = 1'b0;
    logic [W-1:0]  tx_data;
    logic          tx_send;
    logic          tx_busy;
    logic [1:0]    mode = 2'd0;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] err_count;

    int checks = 0;
    int failures = 0;
    int nsend = 0;
    int busy_cnt = 0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    uart_echo_fifo #(
        .W       (W),
        .AW      (AW),
        .CW      (CW),
        .DropErr (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_err     (rx_err),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .mode       (mode),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_busy | force_busy;

    // UART transmitter stand-in: latch the byte on a send request, stay busy for three cycles.
    always @(negedge clk) begin
        if (model_busy) begin
            if (busy_cnt == 1) model_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (tx_send) begin
            obs_q.push_back(tx_data);
            nsend      <= nsend + 1;
            model_busy <= 1'b1;
            busy_cnt   <= 3;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic strobe(input logic [W-1:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        step();
    endtask

    task automatic drain(input string tag);
        int n;
        logic [W-1:0] e, o;
        n = 0;
        while ((exp_q.size() > 0 || model_busy) && n < 300) begin
            step();
            n++;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                check({tag, "_byte"}, o, e);
            end
        end
        check({tag, "_pending"}, exp_q.size(), 0);
        repeat (6) step();
        check({tag, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s;
        // Reset values
        step();
        step();
        check("rst_send", tx_send, 0);
        check("rst_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_err", err_count, 0);
        reset = 1'b1;
        step();

        // Raw echo with latency check
        mode = 2'd0;
        rx_data = 8'h41;
        rx_ready = 1'b1;
        exp_q.push_back(8'h41);
        step();
        check("raw_level1", fifo_level, 1);
        check("raw_send_c0", tx_send, 0);
        rx_ready = 1'b0;
        step();
        check("raw_send_c1", tx_send, 0);
        step();
        check("raw_send_c2", tx_send, 1);
        check("raw_data", tx_data, 8'h41);
        check("raw_level0", fifo_level, 0);
        step();
        check("raw_send_drop", tx_send, 0);
        drain("raw");

        // Burst into a stalled transmitter overflows the 4-entry FIFO
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            strobe(8'(8'h30 + i));
            if (i < 4) exp_q.push_back(8'(8'h30 + i));
        end
        check("burst_level", fifo_level, 4);
        check("burst_drop", drop_count, 2);
        check("burst_ovf", overflow, 1);
        force_busy = 1'b0;
        drain("burst");

        // Uppercase transform
        mode = 2'd1;
        strobe(8'h61); exp_q.push_back(8'h41);
        strobe(8'h7A); exp_q.push_back(8'h5A);
        strobe(8'h5B); exp_q.push_back(8'h5B);
        strobe(8'h7B); exp_q.push_back(8'h7B);
        drain("upper");

        // CR expands to CR LF
        mode = 2'd2;
        strobe(8'h68); exp_q.push_back(8'h68);
        strobe(8'h0D); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        strobe(8'h69); exp_q.push_back(8'h69);
        drain("crlf");
        mode = 2'd0;

        // Reset while a send is pending and a byte is still queued
        rx_data = 8'h42;
        rx_ready = 1'b1;
        exp_q.push_back(8'h42);
        step();
        rx_ready = 1'b0;
        step();
        rx_data = 8'h43;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("mid_send", tx_send, 1);
        check("mid_level", fifo_level, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst2_send", tx_send, 0);
        check("rst2_level", fifo_level, 0);
        check("rst2_ovf", overflow, 0);
        check("rst2_drop", drop_count, 0);
        check("rst2_err", err_count, 0);
        drain("rst2");

        // Byte captured with rx_err high is discarded
        s = nsend;
        rx_err = 1'b1;
        rx_data = 8'h55;
        rx_ready = 1'b1;
        step();
        check("err_drop", drop_count, 1);
        check("err_cnt", err_count, 1);
        check("err_level", fifo_level, 0);
        rx_ready = 1'b0;
        step();
        step();
        check("err_hold", err_count, 1);
        check("err_ovf", overflow, 0);
        rx_err = 1'b0;
        repeat (6) step();
        check("err_nosend", nsend, s);
        for (int i = 0; i < 4; i++) begin
            rx_err = 1'b1;
            step();
            rx_err = 1'b0;
            step();
        end
        check("err_sat", err_count, 3);

        // Sink mode drains one byte per cycle without transmitting
        force_busy = 1'b1;
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'h33);
        check("sink_level3", fifo_level, 3);
        s = nsend;
        mode = 2'd3;
        step();
        check("sink_level2", fifo_level, 2);
        step();
        check("sink_level1", fifo_level, 1);
        step();
        check("sink_level0", fifo_level, 0);
        force_busy = 1'b0;
        repeat (6) step();
        check("sink_nosend", nsend, s);
        check("sink_send", tx_send, 0);
        mode = 2'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
